// File: rtl/vga_timing_gen_if.sv
// Video bus between the raster timing generator and the buffers it addresses.
// The generator is master: it drives addresses, timing and RGB, and samples pixel data.
interface vga_timing_gen_if #(
    parameter int CW    = 10,
    parameter int CBITS = 4
);
    logic [3*CBITS-1:0] vga_data;
    logic [CW-1:0]      h_addr;
    logic [CW-1:0]      v_addr;
    logic [7:0]         char_col;
    logic [3:0]         char_xoff;
    logic [7:0]         char_row;
    logic [4:0]         char_yoff;
    logic               frame_start;
    logic               line_end;
    logic               hsync;
    logic               vsync;
    logic               valid;
    logic [7:0]         vga_r;
    logic [7:0]         vga_g;
    logic [7:0]         vga_b;

    modport master (
        input  vga_data,
        output h_addr, v_addr,
        output char_col, char_xoff, char_row, char_yoff,
        output frame_start, line_end,
        output hsync, vsync, valid,
        output vga_r, vga_g, vga_b
    );

    modport slave (
        output vga_data,
        input  h_addr, v_addr,
        input  char_col, char_xoff, char_row, char_yoff,
        input  frame_start, line_end,
        input  hsync, vsync, valid,
        input  vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with character-cell counters
// and a sync/valid/RGB delay line matching the video-memory read latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CHAR_W   = 9,
    parameter int CHAR_H   = 16,
    parameter int CBITS    = 4,
    parameter int PIPE_DLY = 1,
    parameter int CW       = 10
) (
    input logic              pclk,
    input logic              reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_ACT_M1 = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]    X_LAST   = 4'(CHAR_W - 1);
    localparam logic [4:0]    Y_LAST   = 5'(CHAR_H - 1);
    localparam logic [2:0]    IDLE     = {~HS_POL, ~VS_POL, 1'b0};

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [3:0]    xoff;
    logic [7:0]    col;
    logic [4:0]    yoff;
    logic [7:0]    row;

    logic h_wrap;
    logic v_wrap;
    logic v_vis;
    logic act;
    logic hs_raw;
    logic vs_raw;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign v_vis  = (v_cnt < V_ACT);
    assign act    = (h_cnt < H_ACT) && v_vis;
    assign hs_raw = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
    assign vs_raw = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // Clearing from the last active pixel on keeps the cell counters
    // at 0 through blanking and for the first pixel of the next line.
    always_ff @(posedge pclk) begin
        if (!reset) begin
            xoff <= '0;
            col  <= '0;
        end else if (h_cnt >= H_ACT_M1) begin
            xoff <= '0;
            col  <= '0;
        end else if (xoff == X_LAST) begin
            xoff <= '0;
            col  <= col + 1'b1;
        end else begin
            xoff <= xoff + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            yoff <= '0;
            row  <= '0;
        end else if (h_wrap && v_wrap) begin
            yoff <= '0;
            row  <= '0;
        end else if (h_wrap && v_vis) begin
            if (yoff == Y_LAST) begin
                yoff <= '0;
                row  <= row + 1'b1;
            end else begin
                yoff <= yoff + 1'b1;
            end
        end
    end

    function automatic logic [7:0] expand(input logic [CBITS-1:0] c);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[CBITS-1-(i%CBITS)];
        end
        return e;
    endfunction

    logic [2:0]  raw;
    logic [2:0]  dly;
    logic [23:0] rgb_px;
    logic [23:0] rgb;

    assign raw    = {hs_raw, vs_raw, act};
    assign rgb_px = {expand(bus.vga_data[3*CBITS-1:2*CBITS]),
                     expand(bus.vga_data[2*CBITS-1:CBITS]),
                     expand(bus.vga_data[CBITS-1:0])};

    generate
        if (PIPE_DLY == 0) begin : g_direct
            assign dly = raw;
            assign rgb = act ? rgb_px : '0;
        end else begin : g_pipe
            logic [PIPE_DLY-1:0][2:0] sr;
            logic [PIPE_DLY:0][2:0]   chain;
            logic [23:0]              rgb_q;

            assign chain = {sr, raw};

            // RGB loads alongside the last stage, gated by the valid bit entering it.
            always_ff @(posedge pclk) begin
                if (!reset) begin
                    sr    <= {PIPE_DLY{IDLE}};
                    rgb_q <= '0;
                end else begin
                    sr    <= chain[PIPE_DLY-1:0];
                    rgb_q <= chain[PIPE_DLY-1][0] ? rgb_px : '0;
                end
            end

            assign dly = chain[PIPE_DLY];
            assign rgb = rgb_q;
        end
    endgenerate

    assign bus.h_addr      = act ? h_cnt : '0;
    assign bus.v_addr      = act ? v_cnt : '0;
    assign bus.char_col    = col;
    assign bus.char_xoff   = xoff;
    assign bus.char_row    = row;
    assign bus.char_yoff   = yoff;
    assign bus.frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign bus.line_end    = h_wrap;
    assign bus.hsync       = dly[2];
    assign bus.vsync       = dly[1];
    assign bus.valid       = dly[0];
    assign bus.vga_r       = rgb[23:16];
    assign bus.vga_g       = rgb[15:8];
    assign bus.vga_b       = rgb[7:0];
endmodule
